// File: rtl/fetch_pkg.sv
// Shared widths, FSM encoding and buffer entry layout for the fetch unit.
package fetch_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;   // holds 0..FIFO_DEPTH

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    // One buffered instruction: the word and the address it came from.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer with push, pop and flush.
// Ports: clk, rst (async, active-high); i_push/i_data/i_pc write an entry;
// i_pop drops the head; i_flush empties the buffer (wins over push/pop);
// o_data/o_pc show the head; o_count is the occupancy.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_pc,
    output logic [CNT_W-1:0]  o_count
);

    fetch_entry_t     r_mem [FIFO_DEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    // Pop needs data; push needs room unless the head leaves in the same cycle.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(FIFO_DEPTH)) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{data: i_data, pc: i_pc};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr].data;
    assign o_pc    = r_mem[r_rd_ptr].pc;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: streams words from ROM port A into a 2-entry
// buffer feeding decode, handles redirects, and serves literal reads on
// ROM port B.
// Ports: clk, rst (async, active-high); rom_addr_a/rom_q_a fetch port;
// rom_addr_b/rom_q_b literal port; instr_valid/instr_ready/instr_data/
// instr_pc decode handshake; redir_valid/redir_pc redirect; lit_req/
// lit_addr/lit_valid/lit_data literal request and response.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr_a,
    input  logic [DATA_W-1:0] rom_q_a,
    output logic [ADDR_W-1:0] rom_addr_b,
    input  logic [DATA_W-1:0] rom_q_b,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic              lit_req,
    input  logic [ADDR_W-1:0] lit_addr,
    output logic              lit_valid,
    output logic [DATA_W-1:0] lit_data
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              w_run;

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight_valid;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_lit_valid;
    logic [ADDR_W-1:0] r_lit_addr;

    logic [CNT_W-1:0]  w_count;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [2:0]        w_load;
    logic [2:0]        w_limit;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: IDLE lasts one cycle, RUN holds until reset.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_run = 1'b0;
        if (r_state == ST_RUN) begin
            w_run = 1'b1;
        end
    end

    assign instr_valid = (w_count != '0);
    assign w_pop       = instr_valid && instr_ready;

    // Buffered + in-flight words after this cycle's pop must stay under two.
    assign w_load  = 3'(w_count) + 3'(r_inflight_valid);
    assign w_limit = 3'd2 + 3'(w_pop);
    assign w_issue = w_run && (redir_valid || (w_load < w_limit));

    // A returning fetch is killed when a redirect lands in the same cycle.
    assign w_push = r_inflight_valid && !redir_valid;

    assign rom_addr_a = redir_valid ? redir_pc : r_pc;

    // Fetch pointer and in-flight tag. A redirect seen before RUN only
    // retargets pc, since no fetch is issued yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc             <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
        end else begin
            if (w_issue) begin
                r_pc <= rom_addr_a + ADDR_W'(1);
            end else if (redir_valid) begin
                r_pc <= redir_pc;
            end
            r_inflight_valid <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= rom_addr_a;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (rom_q_a),
        .i_pc    (r_inflight_pc),
        .i_pop   (w_pop),
        .i_flush (redir_valid),
        .o_data  (instr_data),
        .o_pc    (instr_pc),
        .o_count (w_count)
    );

    // Literal port: independent of fetch; address held while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lit_valid <= 1'b0;
            r_lit_addr  <= '0;
        end else begin
            r_lit_valid <= lit_req;
            if (lit_req) begin
                r_lit_addr <= lit_addr;
            end
        end
    end

    assign rom_addr_b = lit_req ? lit_addr : r_lit_addr;
    assign lit_valid  = r_lit_valid;
    assign lit_data   = rom_q_b;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM model, instruction and literal
// scoreboards, stall / redirect / wrap / reset scenarios.
module tb_fetch_unit;

    localparam logic [7:0] RST_PC = 8'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rom_addr_a;
    logic [15:0] rom_q_a;
    logic [7:0]  rom_addr_b;
    logic [15:0] rom_q_b;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [7:0]  instr_pc;
    logic        redir_valid;
    logic [7:0]  redir_pc;
    logic        lit_req;
    logic [7:0]  lit_addr;
    logic        lit_valid;
    logic [15:0] lit_data;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr_a  (rom_addr_a),
        .rom_q_a     (rom_q_a),
        .rom_addr_b  (rom_addr_b),
        .rom_q_b     (rom_q_b),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .lit_req     (lit_req),
        .lit_addr    (lit_addr),
        .lit_valid   (lit_valid),
        .lit_data    (lit_data)
    );

    // 256x16 synchronous-read ROM, contents ROM[i] = i + 16'h100.
    logic [15:0] rom [256];
    always @(posedge clk) begin
        rom_q_a <= rom[rom_addr_a];
        rom_q_b <= rom[rom_addr_b];
    end

    // Stimulus applied at each negedge.
    logic       d_rst, d_ready, d_redir, d_lit;
    logic [7:0] d_rpc, d_laddr;

    int          n_checks;
    int          n_pass;
    int          n_acc;
    logic [7:0]  exp_q [$];
    logic [7:0]  next_push;
    logic [15:0] lit_q [$];
    logic        prev_lit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic sb_restart(input logic [7:0] start);
        exp_q.delete();
        next_push = start;
    endtask

    task automatic sb_refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_push);
            next_push = next_push + 8'd1;
        end
    endtask

    // One clock: drive inputs, then check outputs against the scoreboards.
    task automatic step_cycle();
        logic [7:0]  e_pc;
        logic [15:0] e_lit;
        @(negedge clk);
        rst         = d_rst;
        instr_ready = d_ready;
        redir_valid = d_redir;
        redir_pc    = d_rpc;
        lit_req     = d_lit;
        lit_addr    = d_laddr;
        #1;
        if (d_rst) begin
            prev_lit = 1'b0;
            lit_q.delete();
        end
        chk("lit_valid", 32'(lit_valid), 32'(prev_lit));
        if (prev_lit && lit_valid) begin
            e_lit = lit_q.pop_front();
            chk("lit_data", 32'(lit_data), 32'(e_lit));
        end
        if (instr_valid && instr_ready) begin
            sb_refill();
            e_pc = exp_q.pop_front();
            chk("instr_pc", 32'(instr_pc), 32'(e_pc));
            chk("instr_data", 32'(instr_data), 32'(16'(e_pc) + 16'h0100));
            n_acc++;
        end
        if (d_rst) sb_restart(RST_PC);
        else if (d_redir) sb_restart(d_rpc);
        prev_lit = d_lit && !d_rst;
        if (prev_lit) lit_q.push_back(16'(d_laddr) + 16'h0100);
    endtask

    task automatic check_reset_outputs();
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_data", 32'(instr_data), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_lit_valid", 32'(lit_valid), 32'd0);
    endtask

    // Release reset and measure cycles until the first valid instruction.
    task automatic release_and_measure();
        int first;
        first = -1;
        d_rst = 1'b0;
        d_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step_cycle();
            if (instr_valid && first < 0) first = k;
        end
        chk("first_valid_latency", 32'(first), 32'd3);
    endtask

    logic [7:0] held_pc, held_addr;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'(i) + 16'h0100;
        n_checks = 0; n_pass = 0; n_acc = 0;
        prev_lit = 1'b0;
        sb_restart(RST_PC);
        rst = 1'b1; instr_ready = 1'b0; redir_valid = 1'b0; redir_pc = 8'h00;
        lit_req = 1'b0; lit_addr = 8'h00;
        d_rst = 1'b1; d_ready = 1'b0; d_redir = 1'b0; d_rpc = 8'h00;
        d_lit = 1'b0; d_laddr = 8'h00;

        // Reset state.
        repeat (3) step_cycle();
        check_reset_outputs();
        chk("rst_rom_addr_a", 32'(rom_addr_a), 32'(RST_PC));

        // Start-up latency and one-per-cycle streaming.
        release_and_measure();
        repeat (8) begin
            step_cycle();
            chk("stream_valid", 32'(instr_valid), 32'd1);
        end

        // Stall: head frozen, no new fetch address, literals keep flowing.
        d_ready = 1'b0; d_lit = 1'b1; d_laddr = 8'h80;
        step_cycle();
        held_pc   = instr_pc;
        held_addr = rom_addr_a;
        repeat (4) begin
            step_cycle();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr_pc", 32'(instr_pc), 32'(held_pc));
            chk("stall_fetch_addr", 32'(rom_addr_a), 32'(held_addr));
        end
        d_ready = 1'b1;
        repeat (6) step_cycle();

        // Redirect while the buffer is full and decode is stalled.
        d_ready = 1'b0;
        repeat (3) step_cycle();
        d_redir = 1'b1; d_rpc = 8'h40;
        step_cycle();
        d_redir = 1'b0; d_ready = 1'b1;
        repeat (6) step_cycle();

        // Back-to-back redirects; the first coincides with a pop.
        d_redir = 1'b1; d_rpc = 8'h20;
        step_cycle();
        d_rpc = 8'h30;
        step_cycle();
        d_redir = 1'b0;
        repeat (6) step_cycle();

        // Address wrap FE, FF, 00, 01.
        d_redir = 1'b1; d_rpc = 8'hFE;
        step_cycle();
        d_redir = 1'b0;
        repeat (8) step_cycle();

        // Literal address holds while lit_req is low.
        d_lit = 1'b0; d_laddr = 8'h33;
        step_cycle();
        chk("rom_addr_b_hold", 32'(rom_addr_b), 32'h80);
        step_cycle();

        // Reset mid-stream: immediate clear, restart at RESET_PC.
        d_rst = 1'b1;
        step_cycle();
        check_reset_outputs();
        step_cycle();
        release_and_measure();
        repeat (6) step_cycle();

        chk("accept_count_min", 32'(n_acc >= 35), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
